clk_div_prog: RTL
=================

# clk_div_prog

Programmable synchronous clock divider for the IR transreceiver: derives a square wave and a one-cycle enable strobe from the 100 MHz system clock. The divisor can be changed at runtime, and every change takes effect only at a period boundary, so the output is glitch-free. All state is clocked on clk_i; there is no ripple chain. It feeds the IR carrier modulator and the bit-timing logic.

## Interface
- CNT_W, 16: width of counter, divisor input and divisor readback.
- DIV_RST, 1024: divisor active after reset. 1024 at 100 MHz gives 97.656 kHz.
- clk_i  in  1  system clock, 100 MHz.
- rst  in  1  reset, asynchronous, active-high.
- en_i  in  1  count enable; when low, the divider freezes.
- div_i  in  CNT_W  requested divisor N, in clk_i cycles per output period.
- div_we_i  in  1  write strobe; captures div_i into the pending register.
- clk_o  out  1  divided square wave.
- tick_o  out  1  one-cycle pulse at the start of each output period.
- upd_ack_o  out  1  one-cycle pulse when a pending divisor becomes active.
- div_o  out  CNT_W  currently active divisor, after clamping.

## Operation
- Internal registers:
  - cnt: CNT_W-bit counter.
  - act_div: active divisor.
  - pend_div: pending divisor.
  - pend_v: pending-valid flag.
- Reset values:
  - cnt = DIV_RST-1, so the first enabled edge wraps.
  - act_div = DIV_RST; pend_div = 0; pend_v = 0.
  - clk_o = 0, tick_o = 0, upd_ack_o = 0, div_o = DIV_RST.
- Clamp: a div_i value below 2 is stored as 2. DIV_RST below 2 is a parameter error and must be rejected at elaboration.
- Write: when div_we_i = 1, pend_div <= clamp(div_i) and pend_v <= 1. A later write before the divisor is applied overwrites the pending value (last write wins).
- Enabled edge (en_i = 1):
  - If cnt == act_div-1, wrap: cnt <= 0.
    - If pend_v was set before this edge: act_div <= pend_div, pend_v <= 0, upd_ack_o <= 1.
    - A div_we_i in the same cycle as the wrap is not applied at this wrap; it waits for the next wrap.
  - Otherwise cnt <= cnt+1.
- Output registers, evaluated on the next counter value c and the divisor D in force for that period (the new divisor on a wrap):
  - H = (D+1)>>1.
  - clk_o <= (c < H).
  - tick_o <= (c == 0).
- Duty cycle:
  - Even D: exactly 50 %.
  - Odd D: high (D+1)/2 cycles, low (D-1)/2 cycles.
- en_i = 0:
  - cnt, act_div and clk_o hold.
  - tick_o and upd_ack_o are 0.
  - Writes are still captured.
  - Resuming continues the same period without restarting.
- Width: H and the compare are computed at CNT_W+1 bits, so D = 2^CNT_W-1 does not overflow.
- div_o reflects act_div.
- Reset asserted mid-period: all registers return to their reset values immediately; a pending divisor is discarded.

## Timing
- First enabled edge after reset release: clk_o goes 1 and tick_o goes 1 (registered, visible on the cycle after that edge).
- Output period = D enabled cycles.
- tick_o is coincident with every rising edge of clk_o.
- Divisor update latency: the new divisor applies from the first wrap after the write edge.
  - Worst case: old D + 1 cycles.
  - upd_ack_o coincides with the tick_o that starts the first new-length period.
  - div_o changes on the same edge.
- Output transitions: clk_o never has a high or low phase shorter than min(old, new) phase length.

## Structure
- Shared package ir_clk_pkg holds:
  - localparam CNT_W_DEF = 16.
  - DIV_97K656 = 1024.
  - MIN_DIV = 2.
  - Carrier divisor constants, e.g. DIV_38K = 2632.
- One module, no sub-modules. The clamp and the half-period compute are local functions.

## Test plan
- Reset, en_i = 1, DIV_RST = 1024:
  - clk_o high 512 cycles, low 512 cycles.
  - tick_o every 1024 cycles.
  - div_o = 1024.
- div_i = 5 written mid-period:
  - After the current 1024-cycle period completes, upd_ack_o pulses together with tick_o.
  - clk_o then runs 3 cycles high, 2 low.
  - div_o = 5.
- div_i = 0 and, separately, div_i = 1: both clamp; div_o = 2; clk_o toggles every cycle; tick_o every 2 cycles.
- Two writes, 7 then 9, within one period: only 9 is applied, with a single upd_ack_o. A write on the wrap cycle is applied one period later.
- en_i low for 37 cycles mid-period: clk_o, cnt and div_o hold; no tick_o. Total period = D+37 cycles.
- rst pulsed mid-period with a divisor pending: outputs return to their reset values on the next sample. The pending divisor is not applied; the first period afterwards is 1024 cycles.

Source files
------------

// File: rtl/ir_clk_pkg.sv
// Shared constants for the IR transceiver clock tree: counter width,
// minimum legal divisor and the standard divisors at 100 MHz.
package ir_clk_pkg;

    localparam int CNT_W_DEF  = 16;
    localparam int MIN_DIV    = 2;

    // Divisors for clk_i = 100 MHz
    localparam int DIV_97K656 = 1024;
    localparam int DIV_56K    = 1786;
    localparam int DIV_40K    = 2500;
    localparam int DIV_38K    = 2632;
    localparam int DIV_36K    = 2778;

endpackage

// File: rtl/clk_div_prog.sv
// Programmable glitch-free clock divider: square wave plus period-start strobe.
// Divisor writes are held pending and only take effect at a period wrap.
module clk_div_prog
    import ir_clk_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DIV_RST = DIV_97K656
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             en_i,
    input  logic [CNT_W-1:0] div_i,
    input  logic             div_we_i,
    output logic             clk_o,
    output logic             tick_o,
    output logic             upd_ack_o,
    output logic [CNT_W-1:0] div_o
);

    generate
        if (DIV_RST < MIN_DIV) begin : g_bad_div_rst
            $error("clk_div_prog: DIV_RST must be at least 2");
        end
    endgenerate

    localparam logic [CNT_W-1:0] DIV_RST_V = CNT_W'(DIV_RST);
    localparam logic [CNT_W-1:0] CNT_RST_V = CNT_W'(DIV_RST - 1);

    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
        return (d < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : d;
    endfunction

    // One bit wider so that D = 2^CNT_W-1 rounds up without wrapping.
    function automatic logic [CNT_W:0] half_period(input logic [CNT_W-1:0] d);
        return ({1'b0, d} + (CNT_W+1)'(1)) >> 1;
    endfunction

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act_div;
    logic [CNT_W-1:0] pend_div;
    logic             pend_v;

    logic             wrap;
    logic             apply;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] div_nxt;
    logic             clk_nxt;

    // Next counter value and the divisor governing the period it belongs to
    always_comb begin
        wrap    = (cnt == act_div - CNT_W'(1));
        apply   = wrap && pend_v;
        cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);
        div_nxt = apply ? pend_div : act_div;
        clk_nxt = ({1'b0, cnt_nxt} < half_period(div_nxt));
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            cnt       <= CNT_RST_V;
            act_div   <= DIV_RST_V;
            pend_div  <= '0;
            pend_v    <= 1'b0;
            clk_o     <= 1'b0;
            tick_o    <= 1'b0;
            upd_ack_o <= 1'b0;
        end else begin
            tick_o    <= 1'b0;
            upd_ack_o <= 1'b0;
            if (en_i) begin
                cnt    <= cnt_nxt;
                clk_o  <= clk_nxt;
                tick_o <= wrap;
                if (apply) begin
                    act_div   <= div_nxt;
                    pend_v    <= 1'b0;
                    upd_ack_o <= 1'b1;
                end
            end
            // A write on the wrap edge must survive the clear above and wait a period.
            if (div_we_i) begin
                pend_div <= clamp_div(div_i);
                pend_v   <= 1'b1;
            end
        end
    end

    assign div_o = act_div;

endmodule
